// File: rtl/soc_pb_pkg.sv
// ============================================================================
//  Module  : soc_pb_pkg
//  Purpose : Shared region codes, FSM encoding and error data for soc_pb_router.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package soc_pb_pkg;

   localparam logic [3:0] REG_BRAM  = 4'h0;
   localparam logic [3:0] REG_SPRAM = 4'h1;
   localparam logic [3:0] REG_SPI0  = 4'h2;
   localparam logic [3:0] REG_SPI1  = 4'h3;
   localparam logic [3:0] REG_WB    = 4'h8;

   localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOCAL = 3'd1,
      ST_SPI   = 3'd2,
      ST_WB    = 3'd3,
      ST_RESP  = 3'd4
   } pb_state_t;

endpackage

`default_nettype wire

// File: rtl/soc_pb_timeout.sv
// ============================================================================
//  Module  : soc_pb_timeout
//  Purpose : Wait-cycle counter; flags the wait cycle that reaches 2^TMO_W-1.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module soc_pb_timeout #(
   parameter int TMO_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TMO_W-1:0] LIMIT = '1;

   logic [TMO_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + TMO_W'(1);
      end
   end

   // Asserted on the wait cycle whose increment would bring the count to LIMIT
   assign expired_o = en_i && (cnt_q == (LIMIT - TMO_W'(1)));

endmodule

`default_nettype wire

// File: rtl/soc_pb_router.sv
// ============================================================================
//  Module  : soc_pb_router
//  Purpose : picorv32 native-bus decoder onto BRAM/SPRAM/SPI/Wishbone targets
//            with sticky error capture. Optional timeout: SOC_PB_TIMEOUT_EN.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module soc_pb_router
   import soc_pb_pkg::*;
#(
   parameter int          WB_N      = 6,
   parameter int          WB_AW     = 16,
   parameter int          BRAM_AW   = 8,
   parameter int          SPRAM_AW  = 14,
   parameter int          TMO_W     = 8,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          pb_addr_i,
   input  logic [31:0]          pb_wdata_i,
   input  logic [3:0]           pb_wstrb_i,
   input  logic                 pb_valid_i,
   output logic                 pb_ready_o,
   output logic [31:0]          pb_rdata_o,
   output logic [BRAM_AW-1:0]   bram_addr_o,
   output logic [31:0]          bram_wdata_o,
   output logic [3:0]           bram_wmsk_o,
   output logic                 bram_we_o,
   input  logic [31:0]          bram_rdata_i,
   output logic [SPRAM_AW-1:0]  spram_addr_o,
   output logic [31:0]          spram_wdata_o,
   output logic [3:0]           spram_wmsk_o,
   output logic                 spram_we_o,
   input  logic [31:0]          spram_rdata_i,
   output logic [23:0]          spi_addr_o,
   output logic [31:0]          spi_wdata_o,
   output logic                 spi_we_o,
   output logic                 spi_valid_o,
   output logic                 spi_mem_select_o,
   input  logic [31:0]          spi_rdata_i,
   input  logic                 spi_ready_i,
   output logic [WB_AW-1:0]     wb_addr_o,
   output logic [31:0]          wb_wdata_o,
   output logic [3:0]           wb_wmsk_o,
   output logic                 wb_we_o,
   output logic [WB_N-1:0]      wb_cyc_o,
   input  logic [32*WB_N-1:0]   wb_rdata_i,
   input  logic [WB_N-1:0]      wb_ack_i,
   input  logic                 err_clr_i,
   output logic                 err_pending_o,
   output logic [31:0]          err_addr_o
);

   pb_state_t         state_q;
   logic              pb_ready_q;
   logic [31:0]       rdata_q;
   logic              local_spram_q;
   logic [31:0]       req_addr_q;
   logic [23:0]       spi_addr_q;
   logic [31:0]       spi_wdata_q;
   logic              spi_we_q;
   logic              spi_valid_q;
   logic              spi_sel_q;
   logic [WB_AW-1:0]  wb_addr_q;
   logic [31:0]       wb_wdata_q;
   logic [3:0]        wb_wmsk_q;
   logic              wb_we_q;
   logic [WB_N-1:0]   wb_cyc_q;
   logic              err_pending_q, err_pending_d;
   logic [31:0]       err_addr_q, err_addr_d;

   logic [3:0]        region;
   logic [3:0]        wb_slv;
   logic              is_bram, is_spram, is_spi, is_wb, unmapped;
   logic              accept, req_we;
   logic [WB_N-1:0]   wb_onehot;
   logic [31:0]       wb_sel_rdata;
   logic              wb_hit;
   logic              tmo_expired;
   logic              err_event;
   logic [31:0]       err_src;

   assign region   = pb_addr_i[31:28];
   assign wb_slv   = pb_addr_i[27:24];
   assign is_bram  = (region == REG_BRAM);
   assign is_spram = (region == REG_SPRAM);
   assign is_spi   = (region == REG_SPI0) || (region == REG_SPI1);
   assign is_wb    = (region == REG_WB) && ({28'd0, wb_slv} < WB_N);
   assign unmapped = !(is_bram || is_spram || is_spi || is_wb);
   assign accept   = (state_q == ST_IDLE) && pb_valid_i;
   assign req_we   = |pb_wstrb_i;

   always_comb begin
      wb_onehot = '0;
      for (int i = 0; i < WB_N; i++) begin
         if (wb_slv == 4'(i)) wb_onehot[i] = 1'b1;
      end
   end

   always_comb begin
      wb_sel_rdata = '0;
      for (int i = 0; i < WB_N; i++) begin
         if (wb_cyc_q[i]) wb_sel_rdata = wb_sel_rdata | wb_rdata_i[32*i +: 32];
      end
   end

   assign wb_hit = |(wb_ack_i & wb_cyc_q);

`ifdef SOC_PB_TIMEOUT_EN
   logic tmo_wait;
   assign tmo_wait = ((state_q == ST_SPI) && !spi_ready_i) ||
                     ((state_q == ST_WB) && !wb_hit);

   soc_pb_timeout #(
      .TMO_W     (TMO_W)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q == ST_IDLE),
      .en_i      (tmo_wait),
      .expired_o (tmo_expired)
   );
`else
   // No timeout in this build: SPI/WB accesses wait indefinitely
   assign tmo_expired = (TMO_W == 0);
`endif

   // Local memories see the request combinationally in the accept cycle
   assign bram_addr_o   = pb_addr_i[BRAM_AW+1:2];
   assign bram_wdata_o  = pb_wdata_i;
   assign bram_wmsk_o   = ~pb_wstrb_i;
   assign bram_we_o     = accept && is_bram && req_we;
   assign spram_addr_o  = pb_addr_i[SPRAM_AW+1:2];
   assign spram_wdata_o = pb_wdata_i;
   assign spram_wmsk_o  = ~pb_wstrb_i;
   assign spram_we_o    = accept && is_spram && req_we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pb_ready_q    <= 1'b0;
         rdata_q       <= '0;
         local_spram_q <= 1'b0;
         req_addr_q    <= '0;
         spi_addr_q    <= '0;
         spi_wdata_q   <= '0;
         spi_we_q      <= 1'b0;
         spi_valid_q   <= 1'b0;
         spi_sel_q     <= 1'b0;
         wb_addr_q     <= '0;
         wb_wdata_q    <= '0;
         wb_wmsk_q     <= '0;
         wb_we_q       <= 1'b0;
         wb_cyc_q      <= '0;
      end else begin
         pb_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pb_valid_i) begin
                  req_addr_q <= pb_addr_i;
                  if (is_bram || is_spram) begin
                     local_spram_q <= is_spram;
                     pb_ready_q    <= 1'b1;
                     state_q       <= ST_LOCAL;
                  end else if (is_spi) begin
                     spi_addr_q  <= pb_addr_i[23:0];
                     spi_wdata_q <= pb_wdata_i;
                     spi_we_q    <= req_we;
                     spi_sel_q   <= (region == REG_SPI1);
                     spi_valid_q <= 1'b1;
                     state_q     <= ST_SPI;
                  end else if (is_wb) begin
                     wb_addr_q  <= pb_addr_i[WB_AW+1:2];
                     wb_wdata_q <= pb_wdata_i;
                     wb_wmsk_q  <= ~pb_wstrb_i;
                     wb_we_q    <= req_we;
                     wb_cyc_q   <= wb_onehot;
                     state_q    <= ST_WB;
                  end else begin
                     rdata_q    <= ERR_RDATA;
                     pb_ready_q <= 1'b1;
                     state_q    <= ST_RESP;
                  end
               end
            end
            ST_SPI: begin
               if (spi_ready_i || tmo_expired) begin
                  rdata_q     <= spi_ready_i ? spi_rdata_i : ERR_RDATA;
                  spi_valid_q <= 1'b0;
                  pb_ready_q  <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_WB: begin
               if (wb_hit || tmo_expired) begin
                  rdata_q    <= wb_hit ? wb_sel_rdata : ERR_RDATA;
                  wb_cyc_q   <= '0;
                  pb_ready_q <= 1'b1;
                  state_q    <= ST_RESP;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // A new error outranks a simultaneous clear
   assign err_event = (accept && unmapped) || tmo_expired;
   assign err_src   = (state_q == ST_IDLE) ? pb_addr_i : req_addr_q;

   always_comb begin
      err_pending_d = err_pending_q;
      err_addr_d    = err_addr_q;
      if (err_event && (!err_pending_q || err_clr_i)) begin
         err_pending_d = 1'b1;
         err_addr_d    = err_src;
      end else if (err_clr_i) begin
         err_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_pending_q <= 1'b0;
         err_addr_q    <= '0;
      end else begin
         err_pending_q <= err_pending_d;
         err_addr_q    <= err_addr_d;
      end
   end

   assign pb_ready_o       = pb_ready_q;
   assign pb_rdata_o       = (state_q == ST_LOCAL) ?
                             (local_spram_q ? spram_rdata_i : bram_rdata_i) : rdata_q;
   assign spi_addr_o       = spi_addr_q;
   assign spi_wdata_o      = spi_wdata_q;
   assign spi_we_o         = spi_we_q;
   assign spi_valid_o      = spi_valid_q;
   assign spi_mem_select_o = spi_sel_q;
   assign wb_addr_o        = wb_addr_q;
   assign wb_wdata_o       = wb_wdata_q;
   assign wb_wmsk_o        = wb_wmsk_q;
   assign wb_we_o          = wb_we_q;
   assign wb_cyc_o         = wb_cyc_q;
   assign err_pending_o    = err_pending_q;
   assign err_addr_o       = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_pb_router.sv
// ============================================================================
//  Module  : tb_soc_pb_router
//  Purpose : Directed scoreboard bench for soc_pb_router.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_soc_pb_router;

   localparam int WB_N = 6;
   localparam int WB_AW = 16;
   localparam int BRAM_AW = 8;
   localparam int SPRAM_AW = 14;
   localparam int TMO_W = 4;

   typedef struct {
      bit          chk;
      logic [31:0] d;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] pb_addr = '0, pb_wdata = '0;
   logic [3:0]  pb_wstrb = '0;
   logic        pb_valid = 1'b0;
   logic        pb_ready;
   logic [31:0] pb_rdata;
   logic [BRAM_AW-1:0] bram_addr;
   logic [31:0] bram_wdata, bram_rdata;
   logic [3:0]  bram_wmsk;
   logic        bram_we;
   logic [SPRAM_AW-1:0] spram_addr;
   logic [31:0] spram_wdata, spram_rdata;
   logic [3:0]  spram_wmsk;
   logic        spram_we;
   logic [23:0] spi_addr;
   logic [31:0] spi_wdata;
   logic        spi_we, spi_valid, spi_sel;
   logic [31:0] spi_rdata = '0;
   logic        spi_ready = 1'b0;
   logic [WB_AW-1:0] wb_addr;
   logic [31:0] wb_wdata;
   logic [3:0]  wb_wmsk;
   logic        wb_we;
   logic [WB_N-1:0] wb_cyc;
   logic [32*WB_N-1:0] wb_rdata;
   logic [WB_N-1:0] wb_ack = '0;
   logic        err_clr = 1'b0;
   logic        err_pending;
   logic [31:0] err_addr;

   logic [31:0] bram_mem [0:(1<<BRAM_AW)-1];
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   rsp_id = 0;

   always #5 clk = ~clk;

   soc_pb_router #(
      .WB_N(WB_N), .WB_AW(WB_AW), .BRAM_AW(BRAM_AW), .SPRAM_AW(SPRAM_AW), .TMO_W(TMO_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pb_addr_i(pb_addr), .pb_wdata_i(pb_wdata), .pb_wstrb_i(pb_wstrb), .pb_valid_i(pb_valid),
      .pb_ready_o(pb_ready), .pb_rdata_o(pb_rdata),
      .bram_addr_o(bram_addr), .bram_wdata_o(bram_wdata), .bram_wmsk_o(bram_wmsk),
      .bram_we_o(bram_we), .bram_rdata_i(bram_rdata),
      .spram_addr_o(spram_addr), .spram_wdata_o(spram_wdata), .spram_wmsk_o(spram_wmsk),
      .spram_we_o(spram_we), .spram_rdata_i(spram_rdata),
      .spi_addr_o(spi_addr), .spi_wdata_o(spi_wdata), .spi_we_o(spi_we), .spi_valid_o(spi_valid),
      .spi_mem_select_o(spi_sel), .spi_rdata_i(spi_rdata), .spi_ready_i(spi_ready),
      .wb_addr_o(wb_addr), .wb_wdata_o(wb_wdata), .wb_wmsk_o(wb_wmsk), .wb_we_o(wb_we),
      .wb_cyc_o(wb_cyc), .wb_rdata_i(wb_rdata), .wb_ack_i(wb_ack),
      .err_clr_i(err_clr), .err_pending_o(err_pending), .err_addr_o(err_addr)
   );

   // BRAM: synchronous read returning old data on a same-cycle write
   always @(posedge clk) begin
      if (bram_we)
         bram_mem[bram_addr] <= (bram_mem[bram_addr] & {{8{bram_wmsk[3]}}, {8{bram_wmsk[2]}},
                                 {8{bram_wmsk[1]}}, {8{bram_wmsk[0]}}}) |
                                (bram_wdata & ~{{8{bram_wmsk[3]}}, {8{bram_wmsk[2]}},
                                 {8{bram_wmsk[1]}}, {8{bram_wmsk[0]}}});
      bram_rdata <= bram_mem[bram_addr];
   end

   // SPRAM returns a pattern derived from its word address
   always @(posedge clk) spram_rdata <= 32'h5A00_0000 | {18'd0, spram_addr};

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, got, exp);
   endtask

   // Monitor: every pb_ready pops one expected response
   always @(negedge clk) begin
      if (pb_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_ready: got pb_ready=1 rdata %h, want no response", pb_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) check($sformatf("rsp%0d_rdata", e.id), pb_rdata, e.d);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit push, input bit chk, input logic [31:0] exp);
      @(posedge clk); #1;
      if (push) begin
         exp_q.push_back('{chk: chk, d: exp, id: rsp_id});
         rsp_id++;
      end
      pb_addr = a; pb_wdata = d; pb_wstrb = s; pb_valid = 1'b1;
   endtask

   task automatic wait_ready(input int exp_lat, input string nm);
      int lat = 0;
      forever begin
         @(negedge clk);
         if (pb_ready) break;
         lat++;
         if (lat > 200) break;
      end
      check({nm, "_latency"}, lat, exp_lat);
   endtask

   task automatic release_req();
      @(posedge clk); #1;
      pb_valid = 1'b0; pb_wstrb = '0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < (1 << BRAM_AW); i++) bram_mem[i] = '0;
      for (int i = 0; i < WB_N; i++) wb_rdata[32*i +: 32] = 32'hA5A5_0000 | i;
      wb_rdata[32*2 +: 32] = 32'hCAFE_F00D;
      wb_rdata[32*3 +: 32] = 32'h3333_3333;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_pb_ready", pb_ready, 0);
      check("rst_wb_cyc", wb_cyc, 0);
      check("rst_spi_valid", spi_valid, 0);
      check("rst_err_pending", err_pending, 0);
      check("rst_err_addr", err_addr, 0);

      // BRAM write then read-back
      issue(32'h0000_0010, 32'h1234_5678, 4'hF, 1, 0, 0);
      #1;
      check("bram_wr_addr", bram_addr, 4);
      check("bram_wr_we", bram_we, 1);
      check("bram_wr_wmsk", bram_wmsk, 4'h0);
      wait_ready(1, "bram_wr");
      release_req();
      issue(32'h0000_0010, 0, 4'h0, 1, 1, 32'h1234_5678);
      #1 check("bram_rd_we", bram_we, 0);
      wait_ready(1, "bram_rd");
      release_req();

      // SPRAM write strobes and read
      issue(32'h1000_0040, 32'h0000_BEEF, 4'h3, 1, 0, 0);
      #1;
      check("spram_wr_we", spram_we, 1);
      check("spram_wr_addr", spram_addr, 32'h10);
      check("spram_wr_wmsk", spram_wmsk, 4'hC);
      check("spram_wr_bram_we", bram_we, 0);
      wait_ready(1, "spram_wr");
      release_req();
      issue(32'h1000_0020, 0, 4'h0, 1, 1, 32'h5A00_0008);
      wait_ready(1, "spram_rd");
      release_req();

      // WB read, slave 2 acks after 3 wait cycles; stray acks ignored
      issue(32'h8200_0008, 0, 4'h0, 1, 1, 32'hCAFE_F00D);
      step();
      check("wb_cyc", wb_cyc, 6'b000100);
      check("wb_addr", wb_addr, 2);
      check("wb_we", wb_we, 0);
      wb_ack = 6'b000010;
      step();
      wb_ack = 6'b100000;
      step();
      wb_ack = 6'b000000;
      check("wb_cyc_held", wb_cyc, 6'b000100);
      step();
      wb_ack = 6'b000100;
      step();
      wb_ack = 6'b000000;
      check("wb_ready_after_ack", pb_ready, 1);
      check("wb_cyc_dropped", wb_cyc, 0);
      release_req();

      // SPI0 read, immediate ready: minimum latency 2
      issue(32'h2000_0008, 0, 4'h0, 1, 1, 32'h1122_3344);
      step();
      check("spi0_valid", spi_valid, 1);
      check("spi0_sel", spi_sel, 0);
      check("spi0_addr", spi_addr, 24'h000008);
      spi_ready = 1'b1; spi_rdata = 32'h1122_3344;
      step();
      spi_ready = 1'b0;
      check("spi0_ready", pb_ready, 1);
      release_req();

      // SPI1 byte write with one wait state
      issue(32'h3000_0104, 32'h0000_AB00, 4'h2, 1, 1, 32'h0BAD_F00D);
      #1 check("spi1_wmsk", bram_wmsk, 4'hD);
      step();
      check("spi1_sel", spi_sel, 1);
      check("spi1_addr", spi_addr, 24'h000104);
      check("spi1_we", spi_we, 1);
      check("spi1_wdata", spi_wdata, 32'h0000_AB00);
      step();
      check("spi1_valid_wait", spi_valid, 1);
      spi_ready = 1'b1; spi_rdata = 32'h0BAD_F00D;
      step();
      spi_ready = 1'b0;
      check("spi1_ready", pb_ready, 1);
      check("spi1_valid_drop", spi_valid, 0);
      release_req();

      // Error capture
      issue(32'h5000_0000, 0, 4'h0, 1, 1, 32'hDEAD_BEEF);
      wait_ready(1, "unmapped5");
      check("err1_pending", err_pending, 1);
      check("err1_addr", err_addr, 32'h5000_0000);
      release_req();
      issue(32'h9000_0000, 0, 4'h0, 1, 1, 32'hDEAD_BEEF);
      wait_ready(1, "unmapped9");
      check("err2_addr_kept", err_addr, 32'h5000_0000);
      release_req();
      issue(32'h8600_0000, 0, 4'h0, 1, 1, 32'hDEAD_BEEF);
      wait_ready(1, "wb_slave6");
      check("err3_addr_kept", err_addr, 32'h5000_0000);
      release_req();
      err_clr = 1'b1;
      issue(32'hF000_0004, 0, 4'h0, 1, 1, 32'hDEAD_BEEF);
      step();
      err_clr = 1'b0;
      check("errclr_same_ready", pb_ready, 1);
      check("errclr_same_pending", err_pending, 1);
      check("errclr_same_addr", err_addr, 32'hF000_0004);
      release_req();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("errclr_pending", err_pending, 0);

      // Reset during a WB wait abandons the access
      issue(32'hA000_0000, 0, 4'h0, 1, 1, 32'hDEAD_BEEF);
      wait_ready(1, "unmappedA");
      release_req();
      check("pre_rst_pending", err_pending, 1);
      issue(32'h8100_0000, 0, 4'h0, 0, 0, 0);
      step();
      step();
      check("pre_rst_wb_cyc", wb_cyc, 6'b000010);
      rst_n = 1'b0; pb_valid = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_mid_wb_cyc", wb_cyc, 0);
      check("rst_mid_ready", pb_ready, 0);
      check("rst_mid_pending", err_pending, 0);
      check("rst_mid_err_addr", err_addr, 0);
      repeat (3) step();
      issue(32'h0000_0010, 0, 4'h0, 1, 1, 32'h1234_5678);
      wait_ready(1, "post_rst_bram");
      release_req();

`ifdef SOC_PB_TIMEOUT_EN
      begin
         int n = 0;
         issue(32'h8300_0010, 0, 4'h0, 1, 1, 32'hDEAD_BEEF);
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wb_cyc != 0) n++;
            else if (n > 0) break;
         end
         check("tmo_cyc_cycles", n, 15);
         check("tmo_pending", err_pending, 1);
         check("tmo_err_addr", err_addr, 32'h8300_0010);
         release_req();
         issue(32'h8300_0020, 0, 4'h0, 1, 1, 32'h3333_3333);
         repeat (15) step();
         wb_ack = 6'b001000;
         step();
         wb_ack = '0;
         check("tmo_limit_ack_ready", pb_ready, 1);
         release_req();
      end
`endif

      repeat (4) step();
      check("pending_responses", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
